// File: rtl/muldiv_sequencer.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Latency : 34 cycles from Start acceptance to Done/HI/LO update (32 iterations + settle + fixup).
// Backpressure: Stall holds the front end while Busy and the ID-stage instruction touches HI/LO or issues.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start, i_op       issue of MULT(00)/MULTU(01)/DIV(10)/DIVU(11)
//   i_operand_a/_b      rs / rt values
//   i_hilo_read         MFHI/MFLO present in ID
//   i_hi_write/_lo_write, i_write_data   MTHI/MTLO present in ID and their data
//   o_busy, o_stall     operation in flight / front-end hold request
//   o_done, o_div_by_zero  one-cycle completion pulse and divide-by-zero flag
//   o_hi, o_lo          architectural HI/LO
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_hilo_read,
  input  logic             i_hi_write,
  input  logic             i_lo_write,
  input  logic [WIDTH-1:0] i_write_data,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_DIV   = 2'd2,
    S_FIXUP = 2'd3
  } state_t;

  localparam logic [5:0] ITERS = 6'(WIDTH);

  state_t             r_state;
  logic [5:0]         r_count;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] r_acc;
  // Multiply: |multiplicand|. Divide: |divisor|.
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_result;  // signA ^ signB (product / quotient sign)
  logic               r_sign_a;      // remainder sign
  logic               r_b_zero;
  logic               r_done;
  logic               r_div_by_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand magnitudes at issue; unsigned ops take the raw values.
  logic               w_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  assign w_signed = ~i_op[0];
  assign w_sign_a = w_signed & i_operand_a[WIDTH-1];
  assign w_sign_b = w_signed & i_operand_b[WIDTH-1];
  assign w_abs_a  = w_sign_a ? (~i_operand_a + 1'b1) : i_operand_a;
  assign w_abs_b  = w_sign_b ? (~i_operand_b + 1'b1) : i_operand_b;

  // Shift-add step: the 33-bit sum keeps the carry, which becomes the new MSB
  // after the right shift.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring step: trial-subtract the divisor from the shifted remainder;
  // a borrow (MSB set) means restore, i.e. just keep the shift.
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign fixup. With a zero divisor the restoring loop leaves |A| in the
  // remainder, so applying signA there reproduces the latched signed dividend;
  // only the quotient needs forcing to all ones.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod_fix = r_neg_result ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = r_b_zero     ? {WIDTH{1'b1}}
                    : r_neg_result ? (~r_acc[WIDTH-1:0] + 1'b1)
                    :                r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sign_a ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                               : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_acc         <= '0;
      r_opnd        <= '0;
      r_is_div      <= 1'b0;
      r_neg_result  <= 1'b0;
      r_sign_a      <= 1'b0;
      r_b_zero      <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            // Start has priority; a coincident MTHI/MTLO is dropped.
            r_count      <= '0;
            r_is_div     <= i_op[1];
            r_neg_result <= w_sign_a ^ w_sign_b;
            r_sign_a     <= w_sign_a;
            r_b_zero     <= (i_operand_b == '0);
            if (i_op[1]) begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_opnd  <= w_abs_b;
              r_state <= S_DIV;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
              r_opnd  <= w_abs_a;
              r_state <= S_MUL;
            end
          end else begin
            if (i_hi_write) r_hi <= i_write_data;
            if (i_lo_write) r_lo <= i_write_data;
          end
        end
        S_MUL: begin
          // The count saturates at ITERS; the edge that sees it moves to FIXUP.
          if (r_count == ITERS) begin
            r_state <= S_FIXUP;
          end else begin
            r_acc   <= w_mul_next;
            r_count <= r_count + 6'd1;
          end
        end
        S_DIV: begin
          if (r_count == ITERS) begin
            r_state <= S_FIXUP;
          end else begin
            r_acc   <= w_div_next;
            r_count <= r_count + 6'd1;
          end
        end
        S_FIXUP: begin
          if (r_is_div) begin
            r_hi          <= w_rem_fix;
            r_lo          <= w_quo_fix;
            r_div_by_zero <= r_b_zero;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_stall       = o_busy & (i_start | i_hilo_read | i_hi_write | i_lo_write);
  assign o_done        = r_done;
  assign o_div_by_zero = r_div_by_zero;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Purpose : directed self-checking bench for muldiv_sequencer.
// Latency : checks the 34-cycle Start-to-Done timing and back-to-back issue.
// Backpressure: exercises Stall for MFHI and a re-presented MULTU while Busy.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        hilo_read;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] wdata;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_op          (op),
    .i_operand_a   (opa),
    .i_operand_b   (opb),
    .i_hilo_read   (hilo_read),
    .i_hi_write    (hi_write),
    .i_lo_write    (lo_write),
    .i_write_data  (wdata),
    .o_busy        (busy),
    .o_stall       (stall),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for Done; cyc counts edges after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start = 1'b1; op = o; opa = a; opb = b;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    logic bad;
    logic seen;

    rst_n = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    hilo_read = 1'b0; hi_write = 1'b0; lo_write = 1'b0; wdata = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk1 ("rst_busy",  busy,  1'b0);
    chk1 ("rst_done",  done,  1'b0);
    chk1 ("rst_dbz",   dbz,   1'b0);
    chk1 ("rst_stall", stall, 1'b0);
    chk32("rst_hi",    hi,    32'h0);
    chk32("rst_lo",    lo,    32'h0);
    #10 rst_n = 1'b1;  // released mid-cycle; next edge must accept Start

    // MULT -2 * 3, first edge after reset
    start = 1'b1; op = 2'b00; opa = 32'hFFFF_FFFE; opb = 32'd3;
    tick();
    chk1("mult_busy_after_accept", busy, 1'b1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin tick(); cyc++; end
    chk32("mult_latency", cyc, 32'd34);
    chk32("mult_hi", hi, 32'hFFFF_FFFF);
    chk32("mult_lo", lo, 32'hFFFF_FFFA);
    chk1 ("mult_busy_in_done", busy, 1'b0);
    chk1 ("mult_dbz", dbz, 1'b0);
    tick();
    chk1("mult_done_pulse", done, 1'b0);

    // DIVU 100 / 7
    run_op(2'b11, 32'd100, 32'd7, cyc);
    chk32("divu_latency", cyc, 32'd34);
    chk32("divu_lo", lo, 32'd14);
    chk32("divu_hi", hi, 32'd2);

    // DIV -7 / 2
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
    chk32("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk32("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIV 7 / -2: quotient negative, remainder takes dividend sign
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, cyc);
    chk32("div_negb_lo", lo, 32'hFFFF_FFFD);
    chk32("div_negb_hi", hi, 32'd1);

    // DIV 5 / 0
    run_op(2'b10, 32'd5, 32'd0, cyc);
    chk32("dbz_lo", lo, 32'hFFFF_FFFF);
    chk32("dbz_hi", hi, 32'd5);
    chk1 ("dbz_flag", dbz, 1'b1);
    tick();
    chk1 ("dbz_flag_after", dbz, 1'b0);

    // DIV -5 / 0: HI is the signed dividend
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, cyc);
    chk32("dbz_neg_lo", lo, 32'hFFFF_FFFF);
    chk32("dbz_neg_hi", hi, 32'hFFFF_FFFB);
    chk1 ("dbz_neg_flag", dbz, 1'b1);

    // DIV 0x80000000 / -1
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk32("ovf_lo", lo, 32'h8000_0000);
    chk32("ovf_hi", hi, 32'h0);
    chk1 ("ovf_dbz", dbz, 1'b0);

    // MULTU 0xFFFFFFFF^2
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk32("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk32("multu_max_lo", lo, 32'h0000_0001);

    // MULT (-2^31)^2 = 2^62
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, cyc);
    chk32("mult_min_hi", hi, 32'h4000_0000);
    chk32("mult_min_lo", lo, 32'h0);
    tick();

    // MTHI then MTLO in IDLE, independent
    hi_write = 1'b1; wdata = 32'hAAAA_5555;
    tick();
    hi_write = 1'b0;
    chk32("mthi_hi", hi, 32'hAAAA_5555);
    chk32("mthi_lo_held", lo, 32'h0);
    lo_write = 1'b1; wdata = 32'h1234_5678;
    tick();
    lo_write = 1'b0;
    chk32("mtlo_lo", lo, 32'h1234_5678);
    chk32("mtlo_hi_held", hi, 32'hAAAA_5555);

    // Start with MTHI in the same cycle: Start wins, write dropped
    start = 1'b1; op = 2'b01; opa = 32'd2; opb = 32'd3;
    hi_write = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; hi_write = 1'b0;
    chk1 ("race_busy", busy, 1'b1);
    chk32("race_hi_held", hi, 32'hAAAA_5555);
    // MTLO while Busy is ignored (and stalls)
    lo_write = 1'b1; wdata = 32'h0BAD_0BAD;
    #1;
    chk1("busy_mtlo_stall", stall, 1'b1);
    tick();
    lo_write = 1'b0;
    chk32("busy_mtlo_ignored", lo, 32'h1234_5678);
    cyc = 0;
    while (!done && cyc < 100) begin tick(); cyc++; end
    chk32("race_hi", hi, 32'h0);
    chk32("race_lo", lo, 32'd6);
    tick();

    // MFHI 3 cycles after Start: stall until Done, not in Done
    start = 1'b1; op = 2'b01; opa = 32'd7; opb = 32'd6;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    hilo_read = 1'b1;
    bad = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      #1;
      if (stall !== 1'b1) bad = 1'b1;
      tick();
      cyc++;
    end
    chk1 ("mfhi_stall_held", bad, 1'b0);
    chk1 ("mfhi_stall_done", stall, 1'b0);
    chk32("mfhi_hi", hi, 32'h0);
    chk32("mfhi_lo", lo, 32'd42);
    hilo_read = 1'b0;
    tick();

    // MULTU stalled while Busy, then accepted back-to-back in the Done cycle
    start = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd9;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; op = 2'b01; opa = 32'h0001_0000; opb = 32'h0001_0000;
    bad = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      #1;
      if (stall !== 1'b1) bad = 1'b1;
      tick();
      cyc++;
    end
    chk1 ("b2b_stall_held", bad, 1'b0);
    chk32("b2b_wait", cyc, 32'd31);
    chk1 ("b2b_stall_done", stall, 1'b0);
    chk32("b2b_first_hi", hi, 32'h0);
    chk32("b2b_first_lo", lo, 32'd45);
    tick();
    start = 1'b0;
    chk1("b2b_second_accepted", busy, 1'b1);
    cyc = 0;
    while (!done && cyc < 100) begin tick(); cyc++; end
    chk32("b2b_second_latency", cyc, 32'd34);
    chk32("b2b_second_hi", hi, 32'h1);
    chk32("b2b_second_lo", lo, 32'h0);
    tick();

    // Reset at iteration 10 aborts the operation
    start = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk1 ("abort_busy", busy, 1'b0);
    chk32("abort_hi", hi, 32'h0);
    chk32("abort_lo", lo, 32'h0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk1("abort_no_done", seen, 1'b0);
    lo_write = 1'b1; wdata = 32'h0000_1234;
    tick();
    lo_write = 1'b0;
    chk32("abort_mtlo_lo", lo, 32'h0000_1234);
    chk32("abort_mtlo_hi", hi, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
